// File: rtl/adder_pkg.sv
// Shared helpers and encodings for the pipelined ripple-carry adder/subtractor.
package adder_pkg;

  localparam logic SUB_ADD = 1'b0;
  localparam logic SUB_SUB = 1'b1;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Purely combinational W-bit ripple of full-adder cells; also exposes the carry into its MSB.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] c_s;

  // Full-adder ripple, LSB first.
  always_comb begin
    c_s    = {(W+1){1'b0}};
    sum_o  = {W{1'b0}};
    c_s[0] = c_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c_s[W];
  assign cmsb_o = c_s[W-1];

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per stage, valid/ready on both sides,
// a single global advance so the whole pipe stalls together when the consumer is not ready.
module pipelined_rc_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_rc_adder: WIDTH must be >= 1 and a multiple of STAGES");
  end

  // Each slot carries the full operands; stage k only consumes bits [k*CW +: CW].
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           src_s   [STAGES];
  stage_t           stage_d [STAGES];
  stage_t           stage_q [STAGES];
  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c_eff_s;

  assign b_eff_s   = (sub == SUB_SUB) ? ~b   : b;
  assign c_eff_s   = (sub == SUB_SUB) ? ~cin : cin;
  assign advance_s = !stage_q[STAGES-1].valid || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    ch_sum_s;
    logic             ch_cout_s;
    logic             ch_cmsb_s;
    logic [WIDTH-1:0] s_nxt_s;

    if (k == 0) begin : g_first
      assign src_s[k] = '{valid: in_valid, carry: c_eff_s, ovf: 1'b0,
                          s: {WIDTH{1'b0}}, a: a, b: b_eff_s};
    end else begin : g_next
      assign src_s[k] = stage_q[k-1];
    end

    rca_chunk #(.W(CW)) u_chunk (
      .a_i    (src_s[k].a[k*CW +: CW]),
      .b_i    (src_s[k].b[k*CW +: CW]),
      .c_i    (src_s[k].carry),
      .sum_o  (ch_sum_s),
      .cout_o (ch_cout_s),
      .cmsb_o (ch_cmsb_s)
    );

    // Splice this stage's chunk into the partial sum handed down the pipe.
    always_comb begin
      s_nxt_s              = src_s[k].s;
      s_nxt_s[k*CW +: CW]  = ch_sum_s;
    end

    assign stage_d[k] = '{valid: src_s[k].valid,
                          carry: ch_cout_s,
                          ovf:   (k == STAGES-1) ? signed_ovf(ch_cmsb_s, ch_cout_s) : 1'b0,
                          s:     s_nxt_s,
                          a:     src_s[k].a,
                          b:     src_s[k].b};
  end

  // Stage registers: cleared by reset, shifted together on advance, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].s;
  assign cout      = stage_q[STAGES-1].carry;
  assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Self-checking bench: directed cases on 16/4 and 8/1 instances, random streaming, backpressure
// and mid-stream reset on the 16/4 instance against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_rc_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;

  pipelined_rc_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16)
  );

  pipelined_rc_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];
  bit   mon_en = 1'b0;
  int   out_count = 0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for ovf.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    res_t   r;
    longint m, ua, ub, sa, sb, u, sv;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      u      = ua + ub + longint'(c);
      sv     = sa + sb + longint'(c);
      r.cout = (u >= m);
    end else begin
      u      = ua - ub - longint'(c);
      sv     = sa - sb - longint'(c);
      r.cout = (u >= 0);
    end
    r.sum = 16'(u & (m - 1));
    r.ovf = (sv >= m / 2) || (sv < -(m / 2));
    return r;
  endfunction

  // Scoreboard for the 16/4 instance: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      run_len = 0;
    end else if (mon_en) begin
      if (ov16 && or16) begin
        if (exp_q.size() == 0) begin
          check_eq("stale_out", 32'(ov16), 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check_eq("stream_sum", 32'(s16), 32'(e.sum));
          check_eq("stream_cout", 32'(co16), 32'(e.cout));
          check_eq("stream_ovf", 32'(of16), 32'(e.ovf));
        end
        out_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (iv16 && ir16) exp_q.push_back(model(16, a16, b16, cin16, sub16));
    end
  end

  // Directed op on an idle pipe; checks exact latency and the result fields.
  task automatic do_op(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input res_t e, input string tag);
    int lat;
    lat = (which == 16) ? 4 : 1;
    if (which == 16) begin
      a16 = a; b16 = b; cin16 = c; sub16 = s; iv16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c; sub8 = s; iv8 = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'((which == 16) ? ir16 : ir8), 32'd1);
    @(posedge clk); #1;
    iv16 = 1'b0; iv8 = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check_eq({tag, "_early"}, 32'(ov16), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'((which == 16) ? ov16 : ov8), 32'd1);
    check_eq({tag, "_sum"},   32'((which == 16) ? s16 : {8'h00, s8}), 32'(e.sum));
    check_eq({tag, "_cout"},  32'((which == 16) ? co16 : co8), 32'(e.cout));
    check_eq({tag, "_ovf"},   32'((which == 16) ? of16 : of8), 32'(e.ovf));
    @(posedge clk); #1;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int t;
    t = 0;
    a16 = a; b16 = b; cin16 = c; sub16 = s; iv16 = 1'b1;
    @(negedge clk);
    while (!ir16 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!ir16) check_eq("send_timeout", 32'(ir16), 32'd1);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ov16) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    res_t        e0;

    rst_n = 1'b0;
    iv16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b0;
    iv8  = 1'b0; a8  = 8'h00;    b8  = 8'h00;    cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst16_valid", 32'(ov16), 32'd0);
    check_eq("rst16_sum",   32'(s16),  32'd0);
    check_eq("rst16_cout",  32'(co16), 32'd0);
    check_eq("rst16_ovf",   32'(of16), 32'd0);
    check_eq("rst16_ready", 32'(ir16), 32'd1);
    check_eq("rst8_valid",  32'(ov8),  32'd0);
    check_eq("rst8_sum",    32'(s8),   32'd0);
    check_eq("rst8_ready",  32'(ir8),  32'd1);
    @(posedge clk); #1;
    or16 = 1'b1; or8 = 1'b1;

    do_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0}, "ripple16");
    do_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1}, "povf16");
    do_op(16, 16'h8000, 16'hFFFF, 1'b0, 1'b0, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1}, "novf16");
    do_op(16, 16'h0005, 16'h0007, 1'b0, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0}, "sub16a");
    do_op(16, 16'h0009, 16'h0002, 1'b1, 1'b1, '{sum: 16'h0006, cout: 1'b1, ovf: 1'b0}, "sub16b");

    do_op(8, 16'h00FF, 16'h0001, 1'b0, 1'b0, model(8, 16'h00FF, 16'h0001, 1'b0, 1'b0), "ripple8");
    do_op(8, 16'h007F, 16'h0001, 1'b0, 1'b0, model(8, 16'h007F, 16'h0001, 1'b0, 1'b0), "povf8");
    do_op(8, 16'h0080, 16'h00FF, 1'b0, 1'b0, model(8, 16'h0080, 16'h00FF, 1'b0, 1'b0), "novf8");
    do_op(8, 16'h0005, 16'h0007, 1'b0, 1'b1, model(8, 16'h0005, 16'h0007, 1'b0, 1'b1), "sub8a");
    do_op(8, 16'h0009, 16'h0002, 1'b1, 1'b1, model(8, 16'h0009, 16'h0002, 1'b1, 1'b1), "sub8b");

    // Streaming: 8 back-to-back random ops
    mon_en = 1'b1; out_count = 0; max_run = 0; run_len = 0;
    for (int i = 0; i < 8; i++) begin
      send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_drain();
    check_eq("stream_count", 32'(out_count), 32'd8);
    check_eq("stream_run",   32'(max_run),   32'd8);

    // Backpressure: fill the pipe with out_ready low, stall 3 cycles, then release
    or16 = 1'b0; out_count = 0;
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i == 0) e0 = model(16, ra, rb, rc, rs);
      send16(ra, rb, rc, rs);
    end
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    iv16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(ir16), 32'd0);
      check_eq("bp_valid",    32'(ov16), 32'd1);
      check_eq("bp_sum",      32'(s16),  32'(e0.sum));
      check_eq("bp_cout",     32'(co16), 32'(e0.cout));
      @(posedge clk); #1;
    end
    or16 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    iv16 = 1'b0;
    wait_drain();
    check_eq("bp_count", 32'(out_count), 32'd5);

    // Reset with 3 items in flight
    for (int i = 0; i < 3; i++) begin
      send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst_valid", 32'(ov16), 32'd0);
    check_eq("mrst_sum",   32'(s16),  32'd0);
    check_eq("mrst_cout",  32'(co16), 32'd0);
    check_eq("mrst_ovf",   32'(of16), 32'd0);
    check_eq("mrst_ready", 32'(ir16), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("mrst_quiet", 32'(ov16), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
